seq_num_alloc_arb: RTL and testbench

- Shares the single sequence-number allocation port of the sequence-number generator among p_num_reqs fetch requesters, using round-robin priority.
- A 2-entry prefetch buffer pulls numbers from the generator ahead of demand, so requesters see 1 grant/cycle at full throughput.
- On a squash, all buffered numbers are discarded. They were allocated after every handed-out number, so they are always younger than the squash point and are freed by the generator.

---
 rtl/seq_num_alloc_arb_pkg.sv | 18 +
 rtl/seq_num_alloc_buf.sv | 64 ++++++
 rtl/seq_num_alloc_arb.sv | 79 +++++++
 tb/tb_seq_num_alloc_arb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_num_alloc_arb_pkg.sv
// Shared fetch-side types for sequence-number allocation.
package seq_num_alloc_arb_pkg;

  localparam int SEQ_NUM_BITS    = 5;
  localparam int ALLOC_BUF_DEPTH = 2;
  localparam int ALLOC_PTR_W     = (ALLOC_BUF_DEPTH > 1) ? $clog2(ALLOC_BUF_DEPTH) : 1;
  localparam int ALLOC_CNT_W     = $clog2(ALLOC_BUF_DEPTH + 1);

  typedef logic [SEQ_NUM_BITS-1:0] seq_num_t;

  // Squash notification; the allocator only looks at val.
  typedef struct packed {
    logic     val;
    seq_num_t seq_num;
    seq_num_t target;
  } squash_notif_t;

endpackage

// File: rtl/seq_num_alloc_buf.sv
// Small prefetch FIFO holding sequence numbers pulled ahead of demand.
// A flush empties it in one cycle and rewinds both pointers to entry 0.
module seq_num_alloc_buf
  import seq_num_alloc_arb_pkg::*;
#(
  parameter int p_width = SEQ_NUM_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enq,
  input  logic [p_width-1:0]     i_enq_data,
  input  logic                   i_deq,
  input  logic                   i_flush,
  output logic [ALLOC_CNT_W-1:0] o_count,
  output logic [p_width-1:0]     o_head
);

  logic [p_width-1:0]     r_mem [ALLOC_BUF_DEPTH];
  logic [ALLOC_PTR_W-1:0] r_head;
  logic [ALLOC_PTR_W-1:0] r_tail;
  logic [ALLOC_CNT_W-1:0] r_count;
  logic                   w_enq;
  logic                   w_deq;

  // A flush overrides any same-cycle push or pop.
  assign w_enq = i_enq && !i_flush;
  assign w_deq = i_deq && !i_flush;

  // Entry storage; cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ALLOC_BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_enq) begin
      r_mem[r_tail] <= i_enq_data;
    end
  end

  // Pointer and occupancy tracking, with wrap at the buffer depth.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq)
        r_tail <= (r_tail == ALLOC_PTR_W'(ALLOC_BUF_DEPTH - 1)) ? '0 : r_tail + 1'b1;
      if (w_deq)
        r_head <= (r_head == ALLOC_PTR_W'(ALLOC_BUF_DEPTH - 1)) ? '0 : r_head + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

endmodule

// File: rtl/seq_num_alloc_arb.sv
// Round-robin arbiter sharing the sequence-number generator among fetch
// requesters. A 2-entry prefetch buffer keeps one number ready per cycle;
// a squash drops the buffered numbers, which are younger than anything
// already handed out and are reclaimed by the generator.
module seq_num_alloc_arb
  import seq_num_alloc_arb_pkg::*;
#(
  parameter int p_seq_num_bits = SEQ_NUM_BITS,
  parameter int p_num_reqs     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [p_seq_num_bits-1:0] gen_seq_num,
  input  logic                      gen_val,
  output logic                      gen_rdy,
  input  logic [p_num_reqs-1:0]     req_val,
  output logic [p_num_reqs-1:0]     req_rdy,
  output logic [p_seq_num_bits-1:0] req_seq_num,
  input  squash_notif_t             squash
);

  localparam int PRIO_W = $clog2(p_num_reqs);

  logic [ALLOC_CNT_W-1:0] w_count;
  logic                   w_enq;
  logic                   w_any_gnt;
  logic [PRIO_W-1:0]      w_gnt_idx;
  logic [PRIO_W-1:0]      r_prio_ptr;
  logic                   w_unused_squash;

  // Only the valid bit of the squash notification matters here.
  assign w_unused_squash = ^{squash.seq_num, squash.target};

  // Accepting from the generator never depends on gen_val.
  assign gen_rdy = (w_count < ALLOC_CNT_W'(ALLOC_BUF_DEPTH)) && !squash.val;
  assign w_enq   = gen_val && gen_rdy;

  // Pick the first requesting port at or above the priority pointer.
  always_comb begin
    logic [PRIO_W-1:0] v_sel;
    req_rdy   = '0;
    w_gnt_idx = '0;
    w_any_gnt = 1'b0;
    v_sel     = '0;
    if ((w_count != '0) && !squash.val) begin
      for (int k = 0; k < p_num_reqs; k++) begin
        v_sel = PRIO_W'((int'(r_prio_ptr) + k) % p_num_reqs);
        if (!w_any_gnt && req_val[v_sel]) begin
          req_rdy[v_sel] = 1'b1;
          w_gnt_idx      = v_sel;
          w_any_gnt      = 1'b1;
        end
      end
    end
  end

  // Priority moves just past the last winner; it holds through squashes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio_ptr <= '0;
    end else if (w_any_gnt) begin
      r_prio_ptr <= (w_gnt_idx == PRIO_W'(p_num_reqs - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  seq_num_alloc_buf #(
    .p_width (p_seq_num_bits)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_enq      (w_enq),
    .i_enq_data (gen_seq_num),
    .i_deq      (w_any_gnt),
    .i_flush    (squash.val),
    .o_count    (w_count),
    .o_head     (req_seq_num)
  );

endmodule

// File: tb/tb_seq_num_alloc_arb.sv
// Testbench for seq_num_alloc_arb: directed scenarios plus random traffic,
// checked against a queue-based model of the allocation rules.
module tb_seq_num_alloc_arb;
  import seq_num_alloc_arb_pkg::*;

  localparam int N = 2;
  localparam int W = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  gen_seq_num;
  logic          gen_val;
  logic          gen_rdy;
  logic [N-1:0]  req_val;
  logic [N-1:0]  req_rdy;
  logic [W-1:0]  req_seq_num;
  squash_notif_t squash;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: numbers in FIFO order and the round-robin pointer.
  int           mq[$];
  int           m_prio = 0;
  logic         exp_gen_rdy;
  logic [N-1:0] exp_req_rdy;
  int           exp_g;
  logic [W-1:0] exp_seq;
  bit           exp_has;

  seq_num_alloc_arb #(.p_seq_num_bits(W), .p_num_reqs(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .gen_seq_num (gen_seq_num),
    .gen_val     (gen_val),
    .gen_rdy     (gen_rdy),
    .req_val     (req_val),
    .req_rdy     (req_rdy),
    .req_seq_num (req_seq_num),
    .squash      (squash)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic gv, input int gs, input logic [N-1:0] rv, input logic sq);
    gen_val        = gv;
    gen_seq_num    = W'(gs);
    req_val        = rv;
    squash.val     = sq;
    squash.seq_num = W'($urandom);
    squash.target  = '0;
  endtask

  // Expected combinational outputs for the current inputs.
  task automatic model_expect();
    exp_gen_rdy = (mq.size() < 2) && !squash.val;
    exp_req_rdy = '0;
    exp_g       = -1;
    exp_has     = (mq.size() > 0);
    exp_seq     = exp_has ? W'(mq[0]) : '0;
    if (exp_has && !squash.val) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_prio + k) % N;
        if (exp_g < 0 && req_val[idx]) begin
          exp_g = idx;
          exp_req_rdy[idx] = 1'b1;
        end
      end
    end
  endtask

  // Apply the clock-edge effect of the current inputs to the model.
  task automatic model_commit();
    if (squash.val) begin
      mq.delete();
    end else begin
      if (exp_g >= 0) begin
        void'(mq.pop_front());
        m_prio = (exp_g + 1) % N;
      end
      if (gen_val && exp_gen_rdy) mq.push_back(int'(gen_seq_num));
    end
  endtask

  task automatic next_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_in(0, 0, '0, 0);
    rst = 1'b0;
    #2;
    n_checks++;
    if (req_rdy !== '0) begin n_fail++; $display("FAIL reset_req_rdy got %b want 00", req_rdy); end
    n_checks++;
    if (req_seq_num !== '0) begin n_fail++; $display("FAIL reset_req_seq_num got %0d want 0", req_seq_num); end
    n_checks++;
    if (gen_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_gen_rdy got %b want 1", gen_rdy); end
    mq.delete();
    m_prio = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      set_in(1, c, '0, 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy) begin
        n_fail++;
        $display("FAIL fill c%0d got gen_rdy=%b req_rdy=%b want gen_rdy=%b req_rdy=%b",
                 c, gen_rdy, req_rdy, exp_gen_rdy, exp_req_rdy);
      end
      n_checks++;
      if (gen_rdy !== (c < 2)) begin
        n_fail++;
        $display("FAIL fill_level c%0d got gen_rdy=%b want %b", c, gen_rdy, (c < 2));
      end
      next_cycle();
    end
  endtask

  task automatic test_alternate();
    int k;
    k = 0;
    set_in(0, 0, '0, 1);
    #4; model_expect(); next_cycle();
    for (int c = 0; c < 8; c++) begin
      set_in(c < 6, c, 2'b11, 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL alternate c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      if (req_rdy !== '0) begin
        n_checks++;
        if (req_rdy !== ((k % 2) ? 2'b10 : 2'b01) || req_seq_num !== W'(k)) begin
          n_fail++;
          $display("FAIL alternate_order grant%0d got req_rdy=%b seq=%0d want req_rdy=%b seq=%0d",
                   k, req_rdy, req_seq_num, ((k % 2) ? 2'b10 : 2'b01), k);
        end
        k++;
      end
      next_cycle();
    end
    n_checks++;
    if (k != 6) begin n_fail++; $display("FAIL alternate_count got %0d grants want 6", k); end
  endtask

  task automatic test_single_req();
    int g;
    g = 0;
    for (int c = 0; c < 8; c++) begin
      set_in(1, 10 + c, 2'b10, 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL single_req c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      if (req_rdy !== '0) g++;
      next_cycle();
    end
    n_checks++;
    if (g < 6) begin n_fail++; $display("FAIL single_req_rate got %0d grants want >=6", g); end
  endtask

  task automatic test_squash();
    // Step table: gen_val, gen value, req_val, squash.
    logic         t_gv [6] = '{0, 1, 1, 1, 1, 0};
    int           t_gs [6] = '{0, 7, 8, 9, 7, 0};
    logic [N-1:0] t_rv [6] = '{2'b00, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11};
    logic         t_sq [6] = '{1, 0, 0, 1, 0, 0};
    for (int c = 0; c < 6; c++) begin
      set_in(t_gv[c], t_gs[c], t_rv[c], t_sq[c]);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL squash c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      if (c == 3) begin
        n_checks++;
        if (req_rdy !== '0 || gen_rdy !== 1'b0) begin
          n_fail++;
          $display("FAIL squash_block got req_rdy=%b gen_rdy=%b want 00 0", req_rdy, gen_rdy);
        end
      end
      if (c == 5) begin
        n_checks++;
        if (req_rdy === '0 || req_seq_num !== W'(7)) begin
          n_fail++;
          $display("FAIL squash_after got req_rdy=%b seq=%0d want grant of 7", req_rdy, req_seq_num);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back_squash();
    for (int c = 0; c < 4; c++) begin
      set_in(1, 16 + c, 2'b11, c < 2);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL b2b_squash c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int g;
    g = 0;
    for (int c = 0; c < 5; c++) begin
      set_in(c == 1, 3, (c >= 2) ? 2'b11 : 2'b00, c == 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL stall c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      if (req_rdy !== '0) g++;
      next_cycle();
    end
    n_checks++;
    if (g != 1) begin n_fail++; $display("FAIL stall_grants got %0d want 1", g); end
  endtask

  task automatic test_async_reset();
    // Empty, then grant req0 so the pointer sits at 1, then fill to two.
    logic         t_gv [4] = '{0, 1, 1, 1};
    int           t_gs [4] = '{0, 20, 21, 22};
    logic [N-1:0] t_rv [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
    logic         t_sq [4] = '{1, 0, 0, 0};
    for (int c = 0; c < 4; c++) begin
      set_in(t_gv[c], t_gs[c], t_rv[c], t_sq[c]);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL async_prep c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      next_cycle();
    end
    set_in(0, 0, 2'b11, 0);
    #2;
    model_expect();
    n_checks++;
    if (req_rdy !== exp_req_rdy || gen_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_pending got req_rdy=%b gen_rdy=%b want req_rdy=%b gen_rdy=0", req_rdy, gen_rdy, exp_req_rdy);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_rdy !== '0 || gen_rdy !== 1'b1 || req_seq_num !== '0) begin
      n_fail++;
      $display("FAIL async_reset got req_rdy=%b gen_rdy=%b seq=%0d want 00 1 0", req_rdy, gen_rdy, req_seq_num);
    end
    mq.delete();
    m_prio = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      set_in(1, 24 + c, 2'b11, 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL async_resume c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      if (c == 1) begin
        n_checks++;
        if (req_rdy !== 2'b01 || req_seq_num !== W'(24)) begin
          n_fail++;
          $display("FAIL async_first_grant got req_rdy=%b seq=%0d want 01 24", req_rdy, req_seq_num);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom % 4) != 0, int'($urandom % 32), N'($urandom), ($urandom % 12) == 0);
      #4;
      model_expect();
      n_checks++;
      if (gen_rdy !== exp_gen_rdy || req_rdy !== exp_req_rdy || (exp_has && req_seq_num !== exp_seq)) begin
        n_fail++;
        $display("FAIL random c%0d got gen_rdy=%b req_rdy=%b seq=%0d want gen_rdy=%b req_rdy=%b seq=%0d",
                 c, gen_rdy, req_rdy, req_seq_num, exp_gen_rdy, exp_req_rdy, exp_seq);
      end
      next_cycle();
    end
  endtask

  initial begin
    set_in(0, 0, '0, 0);
    rst = 1'b0;
    test_reset();
    test_fill();
    test_alternate();
    test_single_req();
    test_squash();
    test_back_to_back_squash();
    test_stall();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
